// File: rtl/alu_result_deserializer.sv
// rtl/alu_result_deserializer.sv - ALU serial-link receiver: packet framing and response-frame decode.
// Optional CRC3 check of normal frames is built when ALU_RES_CRC_CHECK_EN is defined.
module alu_result_deserializer #(
  parameter int DATA_PKTS   = 4,
  parameter int GAP_TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sout,
  output logic                   res_valid,
  output logic [8*DATA_PKTS-1:0] res_c,
  output logic [3:0]             res_flags,
  output logic                   res_crc_err,
  output logic                   err_valid,
  output logic [2:0]             err_flags,
  output logic                   err_par_err,
  output logic                   frame_abort
);

  localparam int CW    = 8 * DATA_PKTS;
  localparam int CNT_W = $clog2(DATA_PKTS + 1);
  localparam int GAP_W = $clog2(GAP_TIMEOUT + 1);

  localparam logic [CNT_W-1:0] DATA_FULL = CNT_W'(DATA_PKTS);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_TIMEOUT - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_TYPE    = 2'd1;
  localparam logic [1:0] S_PAYLOAD = 2'd2;
  localparam logic [1:0] S_STOP    = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic             type_q, type_d;
  logic [7:0]       pay_q, pay_d;
  logic [CNT_W-1:0] data_cnt_q, data_cnt_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [CW-1:0]    c_sh_q, c_sh_d;
  logic             res_valid_q, res_valid_d;
  logic [CW-1:0]    res_c_q, res_c_d;
  logic [3:0]       res_flags_q, res_flags_d;
  logic             res_crc_err_q, res_crc_err_d;
  logic             err_valid_q, err_valid_d;
  logic [2:0]       err_flags_q, err_flags_d;
  logic             err_par_err_q, err_par_err_d;
  logic             abort_q, abort_d;
  logic             crc_err;

`ifdef ALU_RES_CRC_CHECK_EN
  // Serial CRC3 (x^3+x+1, init 0) over {C, 1'b0, flags}, MSB first.
  function automatic logic [2:0] crc3(input logic [CW+4:0] msg);
    logic [2:0] c;
    logic       fb;
    c = '0;
    for (int i = CW + 4; i >= 0; i--) begin
      fb = c[2] ^ msg[i];
      c  = {c[1], c[0] ^ fb, fb};
    end
    return c;
  endfunction

  assign crc_err = (crc3({c_sh_q, 1'b0, pay_q[6:3]}) != pay_q[2:0]);
`else
  assign crc_err = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    type_d        = type_q;
    pay_d         = pay_q;
    data_cnt_d    = data_cnt_q;
    gap_d         = '0;
    c_sh_d        = c_sh_q;
    res_valid_d   = 1'b0;
    res_c_d       = res_c_q;
    res_flags_d   = res_flags_q;
    res_crc_err_d = res_crc_err_q;
    err_valid_d   = 1'b0;
    err_flags_d   = err_flags_q;
    err_par_err_d = err_par_err_q;
    abort_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Timeout takes priority; a start bit on that clk still opens a fresh packet.
        if (data_cnt_q != '0) begin
          gap_d = gap_q + GAP_W'(1);
          if (gap_q == GAP_LAST) begin
            abort_d    = 1'b1;
            data_cnt_d = '0;
            gap_d      = '0;
          end
        end
        if (!sout) state_d = S_TYPE;
      end
      S_TYPE: begin
        type_d    = sout;
        bit_cnt_d = 3'd7;
        state_d   = S_PAYLOAD;
      end
      S_PAYLOAD: begin
        pay_d = {pay_q[6:0], sout};
        if (bit_cnt_q == 3'd0) state_d = S_STOP;
        else                   bit_cnt_d = bit_cnt_q - 3'd1;
      end
      default: begin
        state_d = S_IDLE;
        if (!sout) begin
          abort_d    = 1'b1;
          data_cnt_d = '0;
        end else if (!type_q) begin
          if (data_cnt_q < DATA_FULL) begin
            c_sh_d     = CW'({c_sh_q, pay_q});
            data_cnt_d = data_cnt_q + CNT_W'(1);
          end else begin
            abort_d    = 1'b1;
            data_cnt_d = '0;
          end
        end else begin
          data_cnt_d = '0;
          if (data_cnt_q == DATA_FULL) begin
            if (pay_q[7]) begin
              abort_d = 1'b1;
            end else begin
              res_valid_d   = 1'b1;
              res_c_d       = c_sh_q;
              res_flags_d   = pay_q[6:3];
              res_crc_err_d = crc_err;
            end
          end else if (data_cnt_q == '0) begin
            if (!pay_q[7]) begin
              abort_d = 1'b1;
            end else begin
              err_valid_d   = 1'b1;
              err_flags_d   = pay_q[6:4];
              err_par_err_d = (pay_q[6:4] != pay_q[3:1]) || ((^pay_q[7:1]) != pay_q[0]);
            end
          end else begin
            abort_d = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      bit_cnt_q     <= '0;
      type_q        <= 1'b0;
      pay_q         <= '0;
      data_cnt_q    <= '0;
      gap_q         <= '0;
      c_sh_q        <= '0;
      res_valid_q   <= 1'b0;
      res_c_q       <= '0;
      res_flags_q   <= '0;
      res_crc_err_q <= 1'b0;
      err_valid_q   <= 1'b0;
      err_flags_q   <= '0;
      err_par_err_q <= 1'b0;
      abort_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      type_q        <= type_d;
      pay_q         <= pay_d;
      data_cnt_q    <= data_cnt_d;
      gap_q         <= gap_d;
      c_sh_q        <= c_sh_d;
      res_valid_q   <= res_valid_d;
      res_c_q       <= res_c_d;
      res_flags_q   <= res_flags_d;
      res_crc_err_q <= res_crc_err_d;
      err_valid_q   <= err_valid_d;
      err_flags_q   <= err_flags_d;
      err_par_err_q <= err_par_err_d;
      abort_q       <= abort_d;
    end
  end

  assign res_valid   = res_valid_q;
  assign res_c       = res_c_q;
  assign res_flags   = res_flags_q;
  assign res_crc_err = res_crc_err_q;
  assign err_valid   = err_valid_q;
  assign err_flags   = err_flags_q;
  assign err_par_err = err_par_err_q;
  assign frame_abort = abort_q;

endmodule
